// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types for the physical-memory arbiter: FSM state and captured
// operation encoding.
package arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Requester-side and memory-side bus of the arbiter; slave is the arbiter's
// view, master is the view of whatever drives requests and memory responses.
interface mem_arbiter_rr_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256
);

  logic [NUM_REQ-1:0]             req_read;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][LINE_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             req_resp;
  logic [LINE_W-1:0]              req_rdata;

  logic                           pmem_read;
  logic                           pmem_write;
  logic [ADDR_W-1:0]              pmem_addr;
  logic [LINE_W-1:0]              pmem_wdata;
  logic [LINE_W-1:0]              pmem_rdata;
  logic                           pmem_resp;

  logic                           busy;

  modport slave (
    input  req_read, req_write, req_addr, req_wdata, pmem_rdata, pmem_resp,
    output req_resp, req_rdata, pmem_read, pmem_write, pmem_addr, pmem_wdata, busy
  );

  modport master (
    output req_read, req_write, req_addr, req_wdata, pmem_rdata, pmem_resp,
    input  req_resp, req_rdata, pmem_read, pmem_write, pmem_addr, pmem_wdata, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational winner selection: first requesting index at or after the
// search base, wrapping; the base is forced to 0 in fixed-priority mode.
module rr_picker #(
  parameter int NUM_REQ = 2,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               fixed,
  output logic               valid,
  output logic [IW-1:0]      winner
);

  int base;
  int idx;

  // Scan from the far end so the candidate closest to the base is written last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    base   = fixed ? 0 : int'(ptr);
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (base + i) % NUM_REQ;
      if (req[idx]) begin
        valid  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port cacheline arbiter in front of a single physical-memory port; one
// transaction at a time, request fields captured at grant.
module mem_arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_rr_if.slave  bus
);

  localparam int IW = $clog2(NUM_REQ);

  state_t              state_q;
  state_t              state_d;
  op_t                 op_q;
  logic [IW-1:0]       ptr_q;
  logic [IW-1:0]       grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;

  logic [NUM_REQ-1:0]  req_any;
  logic                pick_valid;
  logic [IW-1:0]       pick_idx;
  logic                capture;
  logic                done;

  logic [NUM_REQ-1:0]  resp_vec;
  logic                rd_out;
  logic                wr_out;
  logic                busy_out;

  assign req_any = bus.req_read | bus.req_write;
  assign capture = (state_q == IDLE) && pick_valid;
  assign done    = (state_q == GRANT) && bus.pmem_resp;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req_any),
    .ptr    (ptr_q),
    .fixed  (FIXED_PRI),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid)    state_d = GRANT;
      GRANT:   if (bus.pmem_resp) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_out   = 1'b0;
    wr_out   = 1'b0;
    busy_out = 1'b0;
    resp_vec = '0;
    if (state_q == GRANT) begin
      busy_out = 1'b1;
      rd_out   = (op_q == OP_READ);
      wr_out   = (op_q == OP_WRITE);
      if (bus.pmem_resp) resp_vec[grant_q] = 1'b1;
    end
  end

  // Write wins when a port raises both; the assertion below flags it as illegal.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      grant_q <= pick_idx;
      op_q    <= bus.req_write[pick_idx] ? OP_WRITE : OP_READ;
      addr_q  <= bus.req_addr[pick_idx];
      wdata_q <= bus.req_wdata[pick_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (done && !FIXED_PRI) begin
      ptr_q <= (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);
    end
  end

  assign bus.pmem_read  = rd_out;
  assign bus.pmem_write = wr_out;
  assign bus.pmem_addr  = addr_q;
  assign bus.pmem_wdata = wdata_q;
  assign bus.busy       = busy_out;
  assign bus.req_resp   = resp_vec;
  assign bus.req_rdata  = bus.pmem_rdata;

  a_no_rw_same_port : assert property (
    @(posedge clk) disable iff (!rst) ((bus.req_read & bus.req_write) == '0)
  );

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench: 2-port round-robin, 4-port round-robin fairness and
// 3-port fixed-priority instances sharing one clock and reset.
module tb_mem_arbiter_rr;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mem_arbiter_rr_if #(.NUM_REQ(2)) b2 ();
  mem_arbiter_rr_if #(.NUM_REQ(4)) b4 ();
  mem_arbiter_rr_if #(.NUM_REQ(3)) b3 ();

  mem_arbiter_rr #(.NUM_REQ(2), .FIXED_PRI(1'b0)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  mem_arbiter_rr #(.NUM_REQ(4), .FIXED_PRI(1'b0)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  mem_arbiter_rr #(.NUM_REQ(3), .FIXED_PRI(1'b1)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  localparam logic [255:0] A5   = {32{8'hA5}};
  localparam logic [255:0] DEAD = {8{32'hDEADBEEF}};

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;

    b2.req_read = '0; b2.req_write = '0; b2.req_addr = '0; b2.req_wdata = '0;
    b2.pmem_rdata = '0; b2.pmem_resp = 1'b0;
    b4.req_read = '0; b4.req_write = '0; b4.req_addr = '0; b4.req_wdata = '0;
    b4.pmem_rdata = '0; b4.pmem_resp = 1'b0;
    b3.req_read = '0; b3.req_write = '0; b3.req_addr = '0; b3.req_wdata = '0;
    b3.pmem_rdata = '0; b3.pmem_resp = 1'b0;

    // ---- reset with both ports requesting ----
    b2.req_read    = 2'b11;
    b2.req_addr[0] = 32'h0000_0100;
    b2.req_addr[1] = 32'h0000_1000;
    cyc();
    cyc();
    b2.pmem_resp = 1'b1;
    #1;
    chk("rst_busy",   b2.busy, 0);
    chk("rst_pread",  b2.pmem_read, 0);
    chk("rst_pwrite", b2.pmem_write, 0);
    chk("rst_paddr",  b2.pmem_addr, 0);
    chk("rst_pwdata", b2.pmem_wdata, 0);
    chk("rst_resp",   b2.req_resp, 0);
    b2.pmem_resp = 1'b0;
    rst = 1'b1;
    #1;
    chk("rel_pread_before_edge", b2.pmem_read, 0);
    cyc();
    chk("first_grant_pread", b2.pmem_read, 1);
    chk("first_grant_busy",  b2.busy, 1);
    chk("first_grant_addr",  b2.pmem_addr, 32'h0000_0100);

    // complete port 0; port 0 keeps requesting, so the pointer must move on
    b2.pmem_rdata = 256'h1234;
    b2.pmem_resp  = 1'b1;
    #1;
    chk("p0_resp",  b2.req_resp, 2'b01);
    chk("p0_rdata", b2.req_rdata, 256'h1234);
    cyc();
    b2.pmem_resp = 1'b0;
    chk("turn_idle_pread", b2.pmem_read, 0);
    chk("turn_idle_busy",  b2.busy, 0);
    cyc();

    // ---- single read from port 1 ----
    chk("p1_pread", b2.pmem_read, 1);
    chk("p1_addr",  b2.pmem_addr, 32'h0000_1000);
    cyc(); cyc(); cyc(); cyc();
    chk("p1_hold_busy", b2.busy, 1);
    b2.pmem_rdata = A5;
    b2.pmem_resp  = 1'b1;
    #1;
    chk("p1_resp",  b2.req_resp, 2'b10);
    chk("p1_rdata", b2.req_rdata, A5);
    cyc();
    b2.pmem_resp = 1'b0;
    b2.req_read  = 2'b00;
    chk("p1_after_pread", b2.pmem_read, 0);

    // ---- pmem_resp while idle is ignored ----
    b2.pmem_resp = 1'b1;
    #1;
    chk("idle_resp_ignored", b2.req_resp, 0);
    cyc();
    b2.pmem_resp = 1'b0;
    chk("idle_stays_idle", b2.busy, 0);

    // ---- write from port 0 against read from port 1 ----
    b2.req_write    = 2'b01;
    b2.req_read     = 2'b10;
    b2.req_addr[0]  = 32'h8000_0040;
    b2.req_wdata[0] = DEAD;
    b2.req_wdata[1] = {8{32'h1111_2222}};
    cyc();
    chk("wr_pwrite", b2.pmem_write, 1);
    chk("wr_pread",  b2.pmem_read, 0);
    chk("wr_addr",   b2.pmem_addr, 32'h8000_0040);
    chk("wr_wdata",  b2.pmem_wdata, DEAD);
    b2.req_wdata[0] = '0;
    b2.req_wdata[1] = {8{32'h0BAD_F00D}};
    b2.req_addr[0]  = 32'h0;
    cyc();
    chk("wr_wdata_held", b2.pmem_wdata, DEAD);
    chk("wr_addr_held",  b2.pmem_addr, 32'h8000_0040);
    b2.pmem_resp = 1'b1;
    #1;
    chk("wr_resp", b2.req_resp, 2'b01);
    cyc();
    b2.pmem_resp = 1'b0;
    b2.req_write = 2'b00;
    cyc();
    chk("rd_after_wr_pread", b2.pmem_read, 1);
    chk("rd_after_wr_addr",  b2.pmem_addr, 32'h0000_1000);

    // ---- abort mid-grant: pointer was 1, must come back as 0 ----
    #3;
    rst = 1'b0;
    #1;
    chk("abort_busy",  b2.busy, 0);
    chk("abort_pread", b2.pmem_read, 0);
    chk("abort_addr",  b2.pmem_addr, 0);
    b2.req_read    = 2'b00;
    b2.req_addr[0] = 32'h0000_0100;
    cyc();
    rst = 1'b1;
    b2.pmem_resp = 1'b1;
    #1;
    chk("late_resp_ignored", b2.req_resp, 0);
    cyc();
    b2.pmem_resp = 1'b0;
    chk("late_resp_idle", b2.busy, 0);
    b2.req_read = 2'b11;
    cyc();
    chk("post_abort_ptr0_addr", b2.pmem_addr, 32'h0000_0100);
    b2.pmem_resp = 1'b1;
    b2.req_read  = 2'b00;
    cyc();
    b2.pmem_resp = 1'b0;
    cyc();

    // ---- 4-port round-robin fairness ----
    for (int i = 0; i < 4; i++) b4.req_addr[i] = 32'h1000 + 32'(i) * 32'h40;
    b4.req_read = 4'hF;
    cyc();
    for (int k = 0; k < 6; k++) begin
      int exp_port;
      exp_port = k % 4;
      chk($sformatf("rr_pread_%0d", k), b4.pmem_read, 1);
      chk($sformatf("rr_addr_%0d", k),  b4.pmem_addr, 32'h1000 + 32'(exp_port) * 32'h40);
      cyc();
      b4.pmem_resp = 1'b1;
      #1;
      chk($sformatf("rr_resp_%0d", k), b4.req_resp, 256'(1) << exp_port);
      cyc();
      b4.pmem_resp = 1'b0;
      chk($sformatf("rr_idle_gap_%0d", k), b4.pmem_read, 0);
      cyc();
    end
    b4.pmem_resp = 1'b1;
    b4.req_read  = 4'h0;
    cyc();
    b4.pmem_resp = 1'b0;
    cyc();

    // ---- 3-port fixed priority: port 0 starves port 2 until it drops ----
    b3.req_addr[0] = 32'h2000;
    b3.req_addr[2] = 32'h2080;
    b3.req_read    = 3'b101;
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("fx_addr_%0d", k), b3.pmem_addr, 32'h2000);
      b3.pmem_resp = 1'b1;
      #1;
      chk($sformatf("fx_resp_%0d", k), b3.req_resp, 3'b001);
      cyc();
      b3.pmem_resp = 1'b0;
      cyc();
    end
    b3.pmem_resp = 1'b1;
    b3.req_read  = 3'b100;
    cyc();
    b3.pmem_resp = 1'b0;
    cyc();
    chk("fx_p2_pread", b3.pmem_read, 1);
    chk("fx_p2_addr",  b3.pmem_addr, 32'h2080);
    b3.pmem_resp = 1'b1;
    #1;
    chk("fx_p2_resp", b3.req_resp, 3'b100);
    cyc();
    b3.pmem_resp = 1'b0;
    b3.req_read  = 3'b000;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
